send_bytes_param: RTL and testbench
===================================

SEND_BYTES_PARAM -- requirements
Module: send_bytes_param

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 3: bytes per frame; minimum 1.
REQ-002 SHALL have parameter T0H, default 16: clk cycles datastream is high for a 0 bit.
REQ-003 SHALL have parameter T1H, default 32: clk cycles datastream is high for a 1 bit.
REQ-004 SHALL have parameter TBIT, default 50: total clk cycles per bit; TBIT > T1H > T0H >= 1.
REQ-005 SHALL have parameter TRST, default 2400: clk cycles of low latch time after a frame.
REQ-006 SHALL have port clk  input  1  single system clock; all state on its rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port sck  input  1  SPI serial clock from the host, asynchronous to clk.
REQ-009 SHALL have port sdi  input  1  SPI serial data from the host, valid on sck rising edge.
REQ-010 SHALL have port load  input  1  frame window from the host: high while bits are shifted in, falling edge ends the frame.
REQ-011 SHALL have port datastream  output  1  registered one-wire pulse-width-coded output.
REQ-012 SHALL have port busy  output  1  high from frame start through end of latch time.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse when a frame with the wrong bit count is discarded.

Function
REQ-014 SHALL pass sck, sdi and load each through a 2-flop synchroniser, then edge-detect sck and load on the synchronised values.
REQ-015 SHALL, on each detected sck rise while synchronised load is high, shift synchronised sdi into the LSB of an 8*NUM_BYTES-bit input register.
REQ-016 SHALL count received bits; the counter saturates at 8*NUM_BYTES+1 and clears on each load rise.
REQ-017 SHALL treat the first received bit as frame bit 8*NUM_BYTES-1, i.e. first in, first out on datastream.
REQ-018 SHALL, on a load fall with count exactly 8*NUM_BYTES, mark the input register as a valid pending frame.
REQ-019 SHALL, on a load fall with any other count, discard the input register, pulse frame_err for exactly one cycle, and leave any existing pending frame untouched.
REQ-020 SHALL implement states IDLE, HIGH, LOW, LATCH.
REQ-021 In IDLE with a pending frame, SHALL copy the frame to the output shift register, clear pending, and enter HIGH on the next cycle.
REQ-022 SHALL raise datastream on the first HIGH cycle, which is one clk after the valid load fall is detected.
REQ-023 HIGH SHALL last T1H cycles if the current MSB is 1, otherwise T0H cycles, then enter LOW.
REQ-024 LOW SHALL last TBIT minus the HIGH duration, with datastream low.
REQ-025 At the end of LOW, SHALL shift the output register left and re-enter HIGH if bits remain, otherwise enter LATCH.
REQ-026 LATCH SHALL hold datastream low for TRST cycles, then:
- enter HIGH directly if a frame is pending (copy as in REQ-021);
- otherwise enter IDLE.
REQ-027 SHALL let a new frame be received while busy (double buffering); a later valid frame overwrites an earlier untransmitted pending frame (latest wins).
REQ-028 busy SHALL be high in HIGH, LOW and LATCH, and low only in IDLE.
REQ-029 sck edges while load is low SHALL be ignored.

Reset
REQ-030 While reset is high, SHALL force state IDLE, datastream 0, busy 0, frame_err 0, pending 0, bit counter 0 and all shift registers 0, independent of clk.
REQ-031 Reset asserted mid-frame SHALL abort transmission immediately; after release no residual frame is sent.
REQ-032 Synchroniser flops SHALL reset to 0, so a load already high at reset release is seen as a rise.

Verification
REQ-033 Load high, shift 0xFF0000 (24 bits), load low -> busy rises; 8 bits of 32-high/18-low, then 16 bits of 16-high/34-low; 2400 low cycles; busy falls.
REQ-034 Shift only 23 bits then drop load -> frame_err pulses for one cycle; datastream stays 0; busy stays 0.
REQ-035 During transmission of 0xAAAAAA, load 0x123456 then 0x00000F -> after latch, 0x00000F is sent without a gap in busy; 0x123456 is never sent.
REQ-036 sck toggling with load low, then a valid 24-bit frame of 0x000001 -> only 0x000001 is sent; the last bit uses 32 high cycles.
REQ-037 Reset asserted at bit 10 of a frame -> datastream 0 and busy 0 asynchronously; no output after release until a new valid frame.
REQ-038 With NUM_BYTES=1, T0H=2, T1H=4, TBIT=6, TRST=10, frame 0x81 -> output pattern 4H2L, six times 2H4L, 4H2L, then 10L.

Source files
------------

// File: rtl/send_bytes_param.sv
// SPI-fed frame receiver with double buffering, re-sent as a pulse-width-coded
// one-wire stream (T0H/T1H high time per bit, TRST low latch after each frame).
module send_bytes_param #(
  parameter int unsigned NUM_BYTES = 3,
  parameter int unsigned T0H       = 16,
  parameter int unsigned T1H       = 32,
  parameter int unsigned TBIT      = 50,
  parameter int unsigned TRST      = 2400
) (
  input  logic clk,
  input  logic reset,
  input  logic sck,
  input  logic sdi,
  input  logic load,
  output logic datastream,
  output logic busy,
  output logic frame_err
);

  localparam int unsigned W    = 8 * NUM_BYTES;
  localparam int unsigned BCW  = $clog2(W + 2);
  localparam int unsigned IW   = $clog2(W);
  localparam int unsigned MAXT = (TRST > TBIT) ? TRST : TBIT;
  localparam int unsigned CW   = $clog2(MAXT + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HIGH  = 2'd1;
  localparam logic [1:0] ST_LOW   = 2'd2;
  localparam logic [1:0] ST_LATCH = 2'd3;

  // bit0/bit1 are the synchroniser stages, bit2 holds the previous value for edge detect
  logic [2:0]     sck_sync_q, sck_sync_d;
  logic [2:0]     load_sync_q, load_sync_d;
  logic [1:0]     sdi_sync_q, sdi_sync_d;

  logic [W-1:0]   in_q, in_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic           pend_q, pend_d;
  logic [W-1:0]   pdata_q, pdata_d;

  logic [1:0]     state_q, state_d;
  logic [W-1:0]   sh_q, sh_d;
  logic [IW-1:0]  bit_q, bit_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           ds_q, ds_d;
  logic           busy_q, busy_d;
  logic           ferr_q, ferr_d;

  logic           sck_rise_c, load_rise_c, load_fall_c, load_s_c, sdi_s_c;
  logic [CW-1:0]  hi_len_c;

  assign sck_rise_c  = sck_sync_q[1] & ~sck_sync_q[2];
  assign load_s_c    = load_sync_q[1];
  assign load_rise_c = load_sync_q[1] & ~load_sync_q[2];
  assign load_fall_c = ~load_sync_q[1] & load_sync_q[2];
  assign sdi_s_c     = sdi_sync_q[1];
  assign hi_len_c    = sh_q[W-1] ? CW'(T1H) : CW'(T0H);

  always_comb begin
    sck_sync_d  = {sck_sync_q[1:0], sck};
    load_sync_d = {load_sync_q[1:0], load};
    sdi_sync_d  = {sdi_sync_q[0], sdi};
    in_d        = in_q;
    bcnt_d      = bcnt_q;
    pend_d      = pend_q;
    pdata_d     = pdata_q;
    state_d     = state_q;
    sh_d        = sh_q;
    bit_d       = bit_q;
    cnt_d       = cnt_q;
    ferr_d      = 1'b0;

    // transmitter; taking the pending frame clears pend before the receiver may set it again
    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          sh_d    = pdata_q;
          pend_d  = 1'b0;
          bit_d   = '0;
          cnt_d   = '0;
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (cnt_q == hi_len_c - CW'(1)) begin
          cnt_d   = '0;
          state_d = ST_LOW;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_LOW: begin
        if (cnt_q == CW'(TBIT) - hi_len_c - CW'(1)) begin
          cnt_d = '0;
          if (bit_q == IW'(W - 1)) begin
            state_d = ST_LATCH;
          end else begin
            sh_d    = {sh_q[W-2:0], 1'b0};
            bit_d   = bit_q + IW'(1);
            state_d = ST_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        if (cnt_q == CW'(TRST - 1)) begin
          cnt_d = '0;
          if (pend_q) begin
            sh_d    = pdata_q;
            pend_d  = 1'b0;
            bit_d   = '0;
            state_d = ST_HIGH;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase

    // receiver
    if (load_rise_c) bcnt_d = '0;
    if (sck_rise_c && load_s_c) begin
      in_d = {in_q[W-2:0], sdi_s_c};
      if (bcnt_d != BCW'(W + 1)) bcnt_d = bcnt_d + BCW'(1);
    end
    if (load_fall_c) begin
      if (bcnt_q == BCW'(W)) begin
        pend_d  = 1'b1;
        pdata_d = in_q;
      end else begin
        ferr_d = 1'b1;
      end
      in_d = '0;
    end

    ds_d   = (state_d == ST_HIGH);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync_q  <= '0;
      load_sync_q <= '0;
      sdi_sync_q  <= '0;
      in_q        <= '0;
      bcnt_q      <= '0;
      pend_q      <= 1'b0;
      pdata_q     <= '0;
      state_q     <= ST_IDLE;
      sh_q        <= '0;
      bit_q       <= '0;
      cnt_q       <= '0;
      ds_q        <= 1'b0;
      busy_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      load_sync_q <= load_sync_d;
      sdi_sync_q  <= sdi_sync_d;
      in_q        <= in_d;
      bcnt_q      <= bcnt_d;
      pend_q      <= pend_d;
      pdata_q     <= pdata_d;
      state_q     <= state_d;
      sh_q        <= sh_d;
      bit_q       <= bit_d;
      cnt_q       <= cnt_d;
      ds_q        <= ds_d;
      busy_q      <= busy_d;
      ferr_q      <= ferr_d;
    end
  end

  assign datastream = ds_q;
  assign busy       = busy_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_send_bytes_param.sv
// Directed bench: a default 24-bit instance and a small 8-bit instance share the host inputs.
module tb_send_bytes_param;

  logic clk, reset, sck, sdi, load;
  logic ds_b, busy_b, ferr_b;
  logic ds_s, busy_s, ferr_s;
  int   n_vec, n_err;

  send_bytes_param u_big (
    .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .load(load),
    .datastream(ds_b), .busy(busy_b), .frame_err(ferr_b)
  );

  send_bytes_param #(.NUM_BYTES(1), .T0H(2), .T1H(4), .TBIT(6), .TRST(10)) u_small (
    .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .load(load),
    .datastream(ds_s), .busy(busy_s), .frame_err(ferr_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic ds_of(input bit sel);
    return sel ? ds_s : ds_b;
  endfunction

  function automatic logic busy_of(input bit sel);
    return sel ? busy_s : busy_b;
  endfunction

  // host SPI: MSB first, 4 clk per sck phase
  task automatic send_frame(input logic [23:0] d, input int n);
    load = 1'b1;
    repeat (4) @(posedge clk);
    for (int i = n - 1; i >= 0; i--) begin
      sdi = d[i];
      repeat (4) @(posedge clk);
      sck = 1'b1;
      repeat (4) @(posedge clk);
      sck = 1'b0;
    end
    repeat (4) @(posedge clk);
    load = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  // one bit: high cycles, then low cycles until the next rise or busy drops
  task automatic get_pulse(input bit sel, output int hi, output int lo);
    int n;
    hi = 0; lo = 0; n = 0;
    while (ds_of(sel) == 1'b0 && n < 5000) begin @(negedge clk); n++; end
    while (ds_of(sel) == 1'b1 && hi < 5000) begin hi++; @(negedge clk); end
    while (ds_of(sel) == 1'b0 && busy_of(sel) == 1'b1 && lo < 5000) begin lo++; @(negedge clk); end
  endtask

  task automatic rx_frame(input bit sel, input int n, input int t0h, input int t1h,
                          input int tbit, input int trst,
                          output logic [23:0] data, output int bad);
    int hi, lo, exp_lo;
    data = '0; bad = 0;
    for (int i = 0; i < n; i++) begin
      get_pulse(sel, hi, lo);
      data = {data[22:0], (hi == t1h)};
      if (hi != t0h && hi != t1h) bad++;
      exp_lo = tbit - hi + ((i == n - 1) ? trst : 0);
      if (lo != exp_lo) bad++;
    end
  endtask

  task automatic quiet(input bit sel, input int cycles, output int hits);
    hits = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (ds_of(sel) || busy_of(sel)) hits++;
    end
  endtask

  logic [23:0] data;
  int          bad, hits, hi, lo, ferr_cnt, ds_cnt, busy_cnt;

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1; sck = 1'b0; sdi = 1'b0; load = 1'b0;
    #12;
    chk("rst_ds",   32'(ds_b),   32'd0);
    chk("rst_busy", 32'(busy_b), 32'd0);
    chk("rst_ferr", 32'(ferr_b), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 0xFF0000: eight 32H/18L, sixteen 16H/34L, last low includes the 2400 latch
    fork
      send_frame(24'hFF0000, 24);
      rx_frame(1'b0, 24, 16, 32, 50, 2400, data, bad);
    join
    chk("ff0000_data", 32'(data), 32'h00FF0000);
    chk("ff0000_tim",  32'(bad),  32'd0);
    chk("ff0000_idle", 32'(busy_b), 32'd0);

    // short frame: one-cycle error pulse, no output
    ferr_cnt = 0; ds_cnt = 0; busy_cnt = 0;
    fork
      send_frame(24'h7FFFFF, 23);
      repeat (400) begin
        @(negedge clk);
        if (ferr_b) ferr_cnt++;
        if (ds_b) ds_cnt++;
        if (busy_b) busy_cnt++;
      end
    join
    chk("short_ferr", 32'(ferr_cnt), 32'd1);
    chk("short_ds",   32'(ds_cnt),   32'd0);
    chk("short_busy", 32'(busy_cnt), 32'd0);

    // sck noise with load low is ignored
    sdi = 1'b1;
    for (int i = 0; i < 12; i++) begin
      repeat (4) @(posedge clk); sck = 1'b1;
      repeat (4) @(posedge clk); sck = 1'b0;
    end
    fork
      send_frame(24'h000001, 24);
      rx_frame(1'b0, 24, 16, 32, 50, 2400, data, bad);
    join
    chk("noise_data", 32'(data), 32'h00000001);
    chk("noise_tim",  32'(bad),  32'd0);

    // double buffering: later pending frame replaces earlier one
    fork
      begin
        send_frame(24'hAAAAAA, 24);
        send_frame(24'h123456, 24);
        send_frame(24'h00000F, 24);
      end
      rx_frame(1'b0, 24, 16, 32, 50, 2400, data, bad);
    join
    chk("aa_data", 32'(data), 32'h00AAAAAA);
    chk("aa_tim",  32'(bad),  32'd0);
    chk("aa_nogap", 32'(busy_b), 32'd1);
    rx_frame(1'b0, 24, 16, 32, 50, 2400, data, bad);
    chk("latest_data", 32'(data), 32'h0000000F);
    chk("latest_tim",  32'(bad),  32'd0);
    quiet(1'b0, 3000, hits);
    chk("latest_quiet", 32'(hits), 32'd0);

    // small instance: 0x81 -> 4H2L, six 2H4L, 4H then 2+10 low
    fork
      send_frame(24'h000081, 8);
      rx_frame(1'b1, 8, 2, 4, 6, 10, data, bad);
    join
    chk("small_data", 32'(data), 32'h00000081);
    chk("small_tim",  32'(bad),  32'd0);

    // reset mid-frame, at the start of bit 10
    fork
      send_frame(24'hFFFFFF, 24);
      repeat (10) get_pulse(1'b0, hi, lo);
    join
    chk("pre_rst_ds", 32'(ds_b), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_ds",   32'(ds_b),   32'd0);
    chk("async_rst_busy", 32'(busy_b), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    quiet(1'b0, 3000, hits);
    chk("post_rst_quiet", 32'(hits), 32'd0);
    fork
      send_frame(24'hA5C30F, 24);
      rx_frame(1'b0, 24, 16, 32, 50, 2400, data, bad);
    join
    chk("post_rst_data", 32'(data), 32'h00A5C30F);
    chk("post_rst_tim",  32'(bad),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
